// File: rtl/ucode_loader_if.sv
// Bundle of the loader's data-path signals: the host word stream, the
// program-memory write port and the CPU run/status handshake.
// Signal names are seen from the loader: i_* flow into it, o_* out of it.
interface ucode_loader_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
);
    logic               i_valid;
    logic [DATA_SZ-1:0] i_data;
    logic               o_ready;
    logic               o_wr;
    logic [ADDR_SZ-1:0] o_waddr;
    logic [DATA_SZ-1:0] o_wdata;
    logic               o_run;
    logic               i_running;
    logic               i_status;

    // Loader side
    modport slave (
        input  i_valid, i_data, i_running, i_status,
        output o_ready, o_wr, o_waddr, o_wdata, o_run
    );

    // Host / CPU / memory side
    modport master (
        output i_valid, i_data, i_running, i_status,
        input  o_ready, o_wr, o_waddr, o_wdata, o_run
    );
endinterface

// File: rtl/ucode_loader.sv
// Host-side loader for the uCode CPU: parses LOAD/RUN command words, writes
// program words into program memory and supervises a run with an optional
// cycle budget. All outputs are registered.
module ucode_loader #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    ucode_loader_if.slave bus,
    output logic o_busy,
    output logic o_done,
    output logic o_pass,
    output logic o_timeout,
    output logic o_error
);
    localparam int MEM_MAX = 1 << ADDR_SZ;
    localparam int CNT_W   = ADDR_SZ + 1;   // holds counts up to MEM_MAX
    localparam int BUD_W   = DATA_SZ - 1;   // budget field below the command bit

    localparam logic [DATA_SZ-1:0] MEM_MAX_W = DATA_SZ'(MEM_MAX);
    localparam logic [ADDR_SZ-1:0] ADDR_ONE  = 1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [BUD_W:0]     ELAP_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state, w_state_next;
    logic [ADDR_SZ-1:0] r_addr, w_addr_next;       // next program address
    logic [CNT_W-1:0]   r_left, w_left_next;       // data words still expected
    logic [BUD_W-1:0]   r_budget, w_budget_next;   // 0 = unlimited
    logic [BUD_W-1:0]   r_cycles, w_cycles_next;   // saturating run-cycle count
    logic               r_wr, w_wr_next;
    logic [ADDR_SZ-1:0] r_waddr, w_waddr_next;
    logic [DATA_SZ-1:0] r_wdata, w_wdata_next;
    logic               r_pass, w_pass_next;
    logic               r_timeout, w_timeout_next;
    logic               r_error, w_error_next;
    logic               r_ready, r_run, r_done, r_busy;

    logic                    w_accept;
    logic [DATA_SZ-2:ADDR_SZ] w_cmd_hi;
    logic [BUD_W:0]          w_elapsed;
    logic                    w_stop;
    logic                    w_expire;

    assign w_accept  = bus.i_valid && r_ready;
    assign w_cmd_hi  = bus.i_data[DATA_SZ-2:ADDR_SZ];
    // Cycles o_run will have been high once the current RUN cycle ends.
    assign w_elapsed = {1'b0, r_cycles} + ELAP_ONE;
    // i_running is not trusted in the first RUN cycle (r_cycles still 0).
    assign w_stop    = (r_cycles != '0) && !bus.i_running;
    assign w_expire  = (r_budget != '0) && (w_elapsed == {1'b0, r_budget});

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode and next values for all registered datapath outputs
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_left_next    = r_left;
        w_budget_next  = r_budget;
        w_cycles_next  = r_cycles;
        w_wr_next      = 1'b0;
        w_waddr_next   = r_waddr;
        w_wdata_next   = r_wdata;
        w_pass_next    = r_pass;
        w_timeout_next = r_timeout;
        w_error_next   = r_error;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.i_data[DATA_SZ-1]) begin
                        w_budget_next = bus.i_data[BUD_W-1:0];
                        w_cycles_next = '0;
                        w_state_next  = S_RUN;
                    end else if (w_cmd_hi != '0) begin
                        w_error_next = 1'b1;      // malformed LOAD is dropped
                    end else begin
                        w_addr_next  = bus.i_data[ADDR_SZ-1:0];
                        w_state_next = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (w_accept) begin
                    if (bus.i_data == '0) begin
                        w_state_next = S_IDLE;
                    end else if (bus.i_data > MEM_MAX_W) begin
                        w_error_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_left_next  = bus.i_data[CNT_W-1:0];
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_wr_next    = 1'b1;
                    w_waddr_next = r_addr;
                    w_wdata_next = bus.i_data;
                    w_addr_next  = r_addr + ADDR_ONE;   // wraps modulo MEM_MAX
                    w_left_next  = r_left - CNT_ONE;
                    if (r_left == CNT_ONE) w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cycles != '1) w_cycles_next = w_elapsed[BUD_W-1:0];
                if (w_stop || w_expire) begin
                    w_pass_next    = bus.i_status;
                    w_timeout_next = !w_stop;     // a stop beats a same-cycle expiry
                    w_state_next   = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath and status registers; handshake flags follow the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr    <= '0;
            r_left    <= '0;
            r_budget  <= '0;
            r_cycles  <= '0;
            r_wr      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_error   <= 1'b0;
            r_ready   <= 1'b0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_addr    <= w_addr_next;
            r_left    <= w_left_next;
            r_budget  <= w_budget_next;
            r_cycles  <= w_cycles_next;
            r_wr      <= w_wr_next;
            r_waddr   <= w_waddr_next;
            r_wdata   <= w_wdata_next;
            r_pass    <= w_pass_next;
            r_timeout <= w_timeout_next;
            r_error   <= w_error_next;
            r_ready   <= (w_state_next == S_IDLE) || (w_state_next == S_COUNT) ||
                         (w_state_next == S_DATA);
            r_run     <= (w_state_next == S_RUN);
            r_done    <= (w_state_next == S_DONE);
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_wr    = r_wr;
    assign bus.o_waddr = r_waddr;
    assign bus.o_wdata = r_wdata;
    assign bus.o_run   = r_run;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_timeout   = r_timeout;
    assign o_error     = r_error;
endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: directed scenarios plus randomized
// command streams, checked against a transaction-level model (expected write
// queue, run-length/outcome arithmetic, sticky error flag).
module tb_ucode_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_busy, o_done, o_pass, o_timeout, o_error;

    ucode_loader_if bus ();

    ucode_loader dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_pass   (o_pass),
        .o_timeout(o_timeout),
        .o_error  (o_error)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stalls = 0;
    bit          in_rst = 1'b0;
    bit          mon_on = 1'b0;
    bit          exp_error = 1'b0;
    bit          exp_pass = 1'b0;
    bit          exp_timeout = 1'b0;
    int          exp_done = 0;
    int          done_seen = 0;
    int          run_cur = 0;
    int          last_run_len = 0;
    logic [7:0]  last_waddr = '0;
    logic [15:0] last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every cycle, away from the rising edge
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            if (in_rst) begin
                check("reset_outputs",
                      32'({bus.o_wr, bus.o_run, o_done, o_pass, o_timeout, o_error, o_busy, bus.o_ready}),
                      32'd0);
                run_cur = 0;
            end else begin
                if (bus.o_wr === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr", 32'(bus.o_waddr), 32'hFFFF_FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", 32'(bus.o_waddr), 32'(mon_e.a));
                        check("wr_data", 32'(bus.o_wdata), 32'(mon_e.d));
                        check("wr_cycle", 32'(cyc), 32'(mon_e.c));
                    end
                    last_waddr = bus.o_waddr;
                    last_wdata = bus.o_wdata;
                end
                check("error_flag", 32'(o_error), 32'(exp_error));
                check("pass_flag", 32'(o_pass), 32'(exp_pass));
                check("timeout_flag", 32'(o_timeout), 32'(exp_timeout));
                if (o_done === 1'b1) done_seen++;
                if (bus.o_run === 1'b1) run_cur++;
                else if (run_cur != 0) begin
                    last_run_len = run_cur;
                    run_cur = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Present one word and hold it until accepted; returns at rising edge + 1
    task automatic send_word(input logic [15:0] w, input int gap);
        int i;
        if (gap > 0) begin
            bus.i_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        i = 0;
        forever begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            i++;
            if (i > 200) begin
                failures++;
                $display("FAIL ready_wait actual=0 required=1 word=0x%0h", w);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1);
            end
        end
        stalls += i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        e.c = cyc;
        exp_q.push_back(e);
    endtask

    // LOAD base, count n, then n random data words; model predicts writes/error
    task automatic do_load(input logic [7:0] base, input int n, input int maxgap);
        logic [15:0] d;
        send_word({8'h00, base}, $urandom_range(maxgap, 0));
        send_word(16'(n), $urandom_range(maxgap, 0));
        if (n > 256) exp_error = 1'b1;
        else begin
            for (int k = 0; k < n; k++) begin
                d = 16'($urandom);
                send_word(d, $urandom_range(maxgap, 0));
                push_wr(8'(int'(base) + k), d);
            end
        end
    endtask

    // RUN with budget t; i_running drops from run cycle 'drop' onward
    task automatic do_run(input logic [14:0] t, input int drop, input bit status);
        int s, len;
        bit to;
        s = (drop < 2) ? 2 : drop;
        if (t != 0 && int'(t) < s) begin
            len = int'(t);
            to  = 1'b1;
        end else begin
            len = s;
            to  = 1'b0;
        end
        bus.i_status  = status;
        bus.i_running = 1'b1;
        send_word({1'b1, t}, 0);
        bus.i_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check("run_active", 32'({bus.o_run, bus.o_ready, o_busy}), 32'b101);
            bus.i_running = (k >= drop) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        #1;
        exp_pass    = status;
        exp_timeout = to;
        exp_done++;
        @(negedge clk);
        check("run_end", 32'({bus.o_run, o_done, o_busy}), 32'b011);
        @(negedge clk);
        check("done_pulse", 32'({o_done, o_busy, bus.o_ready}), 32'b001);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_rst      = 1'b1;
        exp_error   = 1'b0;
        exp_pass    = 1'b0;
        exp_timeout = 1'b0;
        bus.i_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        check("ready_after_reset", 32'({bus.o_ready, o_busy}), 32'b10);
    endtask

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        bus.i_running = 1'b0;
        bus.i_status  = 1'b0;

        // Power-on reset
        @(posedge clk);
        #1;
        in_rst = 1'b1;
        mon_on = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        check("ready_after_por", 32'({bus.o_ready, o_busy}), 32'b10);

        // Back-to-back LOAD 0x10, three data words, no bubbles
        stalls = 0;
        send_word(16'h0010, 0);
        send_word(16'h0003, 0);
        send_word(16'hAAAA, 0); push_wr(8'h10, 16'hAAAA);
        send_word(16'hBBBB, 0); push_wr(8'h11, 16'hBBBB);
        send_word(16'hCCCC, 0); push_wr(8'h12, 16'hCCCC);
        idle(2);
        check("burst_stalls", 32'(stalls), 32'd0);
        check("burst_last_addr", 32'(last_waddr), 32'h12);
        check("burst_last_data", 32'(last_wdata), 32'hCCCC);
        check("burst_error", 32'(o_error), 32'd0);

        // Address wrap
        do_load(8'hFE, 4, 0);
        idle(2);
        check("wrap_last_addr", 32'(last_waddr), 32'h01);

        // Malformed LOAD word
        send_word(16'h0100, 0);
        exp_error = 1'b1;
        idle(2);
        check("bad_load_error", 32'({o_error, o_busy}), 32'b10);
        check("bad_load_nowr", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Oversized count
        send_word(16'h0020, 0);
        send_word(16'h0101, 0);
        exp_error = 1'b1;
        idle(2);
        check("big_count_error", 32'({o_error, o_busy}), 32'b10);
        do_reset();

        // Runs: unlimited with stop, budget expiry, stop on the budget cycle
        do_run(15'd0, 21, 1'b0);
        idle(1);
        check("unlimited_len", 32'(last_run_len), 32'd21);
        do_run(15'd5, 100, 1'b1);
        idle(1);
        check("budget_len", 32'(last_run_len), 32'd5);
        check("budget_flags", 32'({o_timeout, o_pass}), 32'b11);
        do_run(15'd5, 5, 1'b1);
        idle(1);
        check("tie_flags", 32'({o_timeout, o_pass, last_run_len[3:0]}), 32'b01_0101);

        // Full-memory count is legal
        do_load(8'h30, 256, 0);
        idle(2);
        check("full_load_error", 32'(o_error), 32'd0);
        check("full_load_last", 32'(last_waddr), 32'h2F);

        // Reset in the middle of a DATA burst with a word on the bus
        send_word(16'h0040, 0);
        send_word(16'h0005, 0);
        send_word(16'h1111, 0); push_wr(8'h40, 16'h1111);
        send_word(16'h2222, 0); push_wr(8'h41, 16'h2222);
        bus.i_data = 16'h5A5A;
        do_reset();
        check("reset_data_drained", 32'(exp_q.size()), 32'd0);
        do_load(8'h80, 3, 0);
        idle(2);
        check("post_reset_load", 32'(last_waddr), 32'h82);

        // Reset during an unlimited RUN
        bus.i_running = 1'b1;
        send_word(16'h8000, 0);
        bus.i_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("run_before_reset", 32'(bus.o_run), 32'd1);
        end
        @(posedge clk);
        #1;
        do_reset();
        idle(2);
        check("no_done_on_reset", 32'(done_seen), 32'(exp_done));
        do_load(8'hC0, 2, 0);
        idle(2);
        check("post_reset_load2", 32'(last_waddr), 32'hC1);

        // Randomized command streams
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(9, 0);
            if (r <= 4) do_load(8'($urandom), $urandom_range(6, 0), 2);
            else if (r == 5) do_load(8'($urandom), 257 + $urandom_range(40, 0), 1);
            else if (r == 6) begin
                send_word({1'b0, 7'($urandom_range(127, 1)), 8'($urandom)}, 1);
                exp_error = 1'b1;
            end else begin
                do_run(15'($urandom_range(12, 0)), $urandom_range(16, 1), 1'($urandom));
            end
            if (it == 20) begin
                idle(2);
                do_reset();
            end
        end

        idle(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_done_count", 32'(done_seen), 32'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
